// File: rtl/levenshtein_pkg.sv
`default_nettype none
// ============================================================================
// Package     : levenshtein_pkg
// Description : Shared result-mode encoding and helpers for the bit-parallel
//               Levenshtein engine (low-bit mask, saturating score step).
// Revision    : 1.0 - initial release
// ============================================================================
package levenshtein_pkg;

    // Result filtering mode; the reserved code behaves as MODE_ALL.
    typedef enum logic [1:0] {
        MODE_ALL    = 2'd0,
        MODE_THRESH = 2'd1,
        MODE_BEST   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Widest pattern the helpers are written for.
    localparam int unsigned MAX_WIDTH = 32;

    // Vector with the low m bits set; callers truncate to their own width.
    function automatic logic [MAX_WIDTH-1:0] low_mask(input int unsigned m);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < m) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // One score step: +1 on inc, -1 on dec, never below zero. Once the score
    // reaches maxv it stays there so an overflowed distance cannot wrap back
    // to a small, misleading value.
    function automatic logic [31:0] sat_step(input logic [31:0] a,
                                             input logic        inc,
                                             input logic        dec,
                                             input logic [31:0] maxv);
        logic [31:0] r;
        r = a;
        if (a >= maxv) begin
            r = maxv;
        end else if (inc && !dec) begin
            r = a + 32'd1;
        end else if (dec && !inc && (a != 32'd0)) begin
            r = a - 32'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/myers_step.sv
`default_nettype none
// ============================================================================
// Module      : myers_step
// Description : Combinational Myers/Hyyro column step. Given the match vector
//               of one dictionary char and the current VP/VN vectors, returns
//               the next VP/VN and whether the last-row score rises or falls.
// Revision    : 1.0 - initial release
// ============================================================================
module myers_step
    import levenshtein_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] eq_i,
    input  logic [WIDTH-1:0] vp_i,
    input  logic [WIDTH-1:0] vn_i,
    input  logic [MW-1:0]    m_i,
    output logic [WIDTH-1:0] vp_o,
    output logic [WIDTH-1:0] vn_o,
    output logic             inc_o,
    output logic             dec_o
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_eq;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_d0;
    logic [WIDTH-1:0] w_hp;
    logic [WIDTH-1:0] w_hn;
    logic [WIDTH-1:0] w_hp_s;
    logic [WIDTH-1:0] w_hn_s;

    assign w_mask = WIDTH'(low_mask(32'(m_i)));
    // One-hot at row m-1 (empty when m=0); picks the last pattern row
    // without a variable bit index.
    assign w_top  = w_mask & ~(w_mask >> 1);

    // Bits above m are ignored so stray match bits cannot leak in.
    assign w_eq   = eq_i & w_mask;
    assign w_x    = w_eq | vn_i;
    assign w_d0   = (((w_eq & vp_i) + vp_i) ^ vp_i) | w_x;
    assign w_hp   = vn_i | ~(w_d0 | vp_i);
    assign w_hn   = vp_i & w_d0;

    // Row 0 boundary: the top edge of the DP matrix always increments.
    assign w_hp_s = {w_hp[WIDTH-2:0], 1'b1};
    assign w_hn_s = {w_hn[WIDTH-2:0], 1'b0};

    assign vp_o   = (w_hn_s | ~(w_d0 | w_hp_s)) & w_mask;
    assign vn_o   = (w_hp_s & w_d0) & w_mask;

    // Score delta from the last row; an empty pattern costs one per char.
    always_comb begin
        inc_o = 1'b0;
        dec_o = 1'b0;
        if (m_i == '0) begin
            inc_o = 1'b1;
        end else begin
            inc_o = |(w_hp & w_top);
            dec_o = |(w_hn & w_top);
        end
    end

endmodule
`default_nettype wire

// File: rtl/levenshtein_bitpar.sv
`default_nettype none
// ============================================================================
// Module      : levenshtein_bitpar
// Description : Streaming global edit distance between a loaded pattern and
//               each dictionary word, one match vector per beat. Results are
//               tagged with a word index and filtered as ALL / THRESH / BEST
//               into a one-deep AXI-stream output register.
// Revision    : 1.0 - initial release
// ============================================================================
module levenshtein_bitpar
    import levenshtein_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIST_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [$clog2(WIDTH+1)-1:0]     word_size,
    input  logic [1:0]                     mode,
    input  logic [DIST_W-1:0]              threshold,
    input  logic                           flush,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [WIDTH-1:0]               s_axis_tdata,
    input  logic                           s_axis_tuser,
    input  logic                           s_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [DIST_W-1:0]              m_axis_tdata,
    output logic [IDX_W-1:0]               m_axis_tuser
);

    localparam int                MW        = $clog2(WIDTH + 1);
    localparam logic [MW-1:0]     M_MAX     = MW'(WIDTH);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;
    localparam logic [DIST_W-1:0] SCORE_RST =
        DIST_W'(sat_step(32'(WIDTH), 1'b0, 1'b0, 32'(DIST_MAX)));

    // Column state of the word in progress
    logic [WIDTH-1:0]  vp_q, vp_d;
    logic [WIDTH-1:0]  vn_q, vn_d;
    logic [DIST_W-1:0] score_q, score_d;
    logic [MW-1:0]     m_q, m_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    // BEST tracker
    logic [DIST_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              flush_pend_q, flush_pend_d;
    // Output register
    logic              out_valid_q, out_valid_d;
    logic [DIST_W-1:0] out_dist_q, out_dist_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;

    logic              w_ready;
    logic              w_acc;
    logic              w_fin;
    logic [MW-1:0]     w_m_clamp;
    logic [MW-1:0]     w_m_in;
    logic [WIDTH-1:0]  w_vp_in;
    logic [WIDTH-1:0]  w_vn_in;
    logic [DIST_W-1:0] w_score_in;
    logic [WIDTH-1:0]  w_vp_nx;
    logic [WIDTH-1:0]  w_vn_nx;
    logic              w_inc;
    logic              w_dec;
    logic [DIST_W-1:0] w_score_nx;
    logic              w_is_thresh;
    logic              w_is_best;
    logic              w_res_load;
    logic              w_best_upd;
    logic [DIST_W-1:0] w_best_cur;
    logic [IDX_W-1:0]  w_best_idx_cur;
    logic              w_flush_req;
    logic              w_free;
    logic              w_flush_go;

    // Input is stalled whenever the output register is full and not
    // draining; stalling non-tlast beats too keeps the control trivial.
    assign w_ready       = !(out_valid_q && !m_axis_tready);
    assign w_free        = w_ready;
    assign s_axis_tready = w_ready;
    assign w_acc         = s_axis_tvalid && w_ready;
    assign w_fin         = w_acc && s_axis_tlast;

    // A tuser beat restarts the column from the fresh-pattern state.
    assign w_m_clamp  = (word_size > M_MAX) ? M_MAX : word_size;
    assign w_m_in     = s_axis_tuser ? w_m_clamp : m_q;
    assign w_vp_in    = s_axis_tuser ? WIDTH'(low_mask(32'(w_m_clamp))) : vp_q;
    assign w_vn_in    = s_axis_tuser ? '0 : vn_q;
    assign w_score_in = s_axis_tuser
                      ? DIST_W'(sat_step(32'(w_m_clamp), 1'b0, 1'b0, 32'(DIST_MAX)))
                      : score_q;

    myers_step #(
        .WIDTH (WIDTH),
        .MW    (MW)
    ) u_step (
        .eq_i  (s_axis_tdata),
        .vp_i  (w_vp_in),
        .vn_i  (w_vn_in),
        .m_i   (w_m_in),
        .vp_o  (w_vp_nx),
        .vn_o  (w_vn_nx),
        .inc_o (w_inc),
        .dec_o (w_dec)
    );

    assign w_score_nx = DIST_W'(sat_step(32'(w_score_in), w_inc, w_dec, 32'(DIST_MAX)));

    // Mode filter; the reserved code falls through to ALL.
    assign w_is_thresh = (mode == MODE_THRESH);
    assign w_is_best   = (mode == MODE_BEST);
    assign w_res_load  = w_fin && !w_is_best &&
                         (!w_is_thresh || (w_score_nx <= threshold));

    // Strict less-than so ties keep the earlier word. The same-cycle view
    // lets a flush coinciding with tlast include that word.
    assign w_best_upd     = w_fin && w_is_best && (w_score_nx < best_q);
    assign w_best_cur     = w_best_upd ? w_score_nx : best_q;
    assign w_best_idx_cur = w_best_upd ? idx_q : best_idx_q;

    // A flush waits for a free output register and yields to a tlast result
    // that claims the register in the same cycle.
    assign w_flush_req = (flush && w_is_best) || flush_pend_q;
    assign w_flush_go  = w_flush_req && w_free && !w_res_load;

    // Next-state for column state, index, BEST tracker and output register.
    always_comb begin
        vp_d         = vp_q;
        vn_d         = vn_q;
        score_d      = score_q;
        m_d          = m_q;
        idx_d        = idx_q;
        best_d       = best_q;
        best_idx_d   = best_idx_q;
        flush_pend_d = w_flush_req && !w_flush_go;
        out_valid_d  = out_valid_q;
        out_dist_d   = out_dist_q;
        out_idx_d    = out_idx_q;

        if (w_acc) begin
            vp_d    = w_vp_nx;
            vn_d    = w_vn_nx;
            score_d = w_score_nx;
            m_d     = w_m_in;
        end

        if (w_fin) begin
            idx_d = idx_q + IDX_W'(1);
        end

        if (w_flush_go) begin
            best_d     = DIST_MAX;
            best_idx_d = '0;
        end else if (w_best_upd) begin
            best_d     = w_score_nx;
            best_idx_d = idx_q;
        end

        if (w_res_load) begin
            out_valid_d = 1'b1;
            out_dist_d  = w_score_nx;
            out_idx_d   = idx_q;
        end else if (w_flush_go) begin
            out_valid_d = 1'b1;
            out_dist_d  = w_best_cur;
            out_idx_d   = w_best_idx_cur;
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any partial word and held result.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            vp_q         <= '1;
            vn_q         <= '0;
            score_q      <= SCORE_RST;
            m_q          <= M_MAX;
            idx_q        <= '0;
            best_q       <= DIST_MAX;
            best_idx_q   <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_dist_q   <= '0;
            out_idx_q    <= '0;
        end else begin
            vp_q         <= vp_d;
            vn_q         <= vn_d;
            score_q      <= score_d;
            m_q          <= m_d;
            idx_q        <= idx_d;
            best_q       <= best_d;
            best_idx_q   <= best_idx_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_dist_q   <= out_dist_d;
            out_idx_q    <= out_idx_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_dist_q;
    assign m_axis_tuser  = out_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_levenshtein_bitpar.sv
`default_nettype none
// ============================================================================
// Module      : tb_levenshtein_bitpar
// Description : Scoreboard bench for levenshtein_bitpar (WIDTH=16, DIST_W=8,
//               IDX_W=8) with pattern "KITTEN" and hand-computed distances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_levenshtein_bitpar;

    localparam int WIDTH  = 16;
    localparam int DIST_W = 8;
    localparam int IDX_W  = 8;
    localparam int MW     = $clog2(WIDTH + 1);

    // Words against pattern KITTEN, first char in the most significant slot.
    localparam logic [127:0] W_KITTEN  = {16'h0001, 16'h0002, 16'h000C,
                                          16'h000C, 16'h0010, 16'h0020};
    localparam logic [127:0] W_SITTING = {16'h0000, 16'h0002, 16'h000C, 16'h000C,
                                          16'h0002, 16'h0020, 16'h0000};

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [MW-1:0]     word_size = MW'(6);
    logic [1:0]        mode = 2'd0;
    logic [DIST_W-1:0] threshold = '0;
    logic              flush = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [WIDTH-1:0]  s_tdata = '0;
    logic              s_tuser = 1'b0;
    logic              s_tlast = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [DIST_W-1:0] m_tdata;
    logic [IDX_W-1:0]  m_tuser;

    typedef struct packed {
        logic [DIST_W-1:0] d;
        logic [IDX_W-1:0]  i;
    } res_t;

    res_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 aclk = ~aclk;

    levenshtein_bitpar #(
        .WIDTH  (WIDTH),
        .DIST_W (DIST_W),
        .IDX_W  (IDX_W)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .word_size     (word_size),
        .mode          (mode),
        .threshold     (threshold),
        .flush         (flush),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/unexpected want event", name);
    endtask

    // Monitor: samples just before each rising edge, pops on handshake.
    initial begin : p_monitor
        logic [15:0] hold_data;
        logic        hold_v;
        res_t        r;
        hold_v    = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge aclk);
            #4;
            if (areset) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_stable", 32'({m_tdata, m_tuser}), 32'(hold_data));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        r = exp_q.pop_front();
                        chk("dist", 32'(m_tdata), 32'(r.d));
                        chk("idx", 32'(m_tuser), 32'(r.i));
                    end
                end
                hold_v    = m_tvalid && !m_tready;
                hold_data = {m_tdata, m_tuser};
            end
        end
    end

    // Present one beat at a negedge and return at the negedge after acceptance.
    task automatic beat(input logic [15:0] eq, input logic u, input logic l);
        int n;
        n = 0;
        s_tdata  = eq;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        #1;
        while (!s_tready && n < 200) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (n >= 200) begin
            fail_now("beat_accept");
        end else begin
            @(posedge aclk);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_word(input logic [127:0] eqs, input int len, input logic fl);
        for (int k = 0; k < len; k++) begin
            if (k == len - 1) flush = fl;
            beat(eqs[16*(len-1-k) +: 16], k == 0, k == len - 1);
        end
        flush = 1'b0;
    endtask

    task automatic push(input int d, input int i);
        exp_q.push_back({DIST_W'(d), IDX_W'(i)});
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2;
        areset   = 1'b1;
        s_tvalid = 1'b0;
        flush    = 1'b0;
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin : p_watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_stim
        time t0;

        // 1: single word SITTING vs KITTEN
        do_reset();
        mode = 2'd0;
        word_size = MW'(6);
        push(3, 0);
        send_word(W_SITTING, 7, 1'b0);

        // 2: ALL mode, two words
        do_reset();
        push(0, 0);
        send_word(W_KITTEN, 6, 1'b0);
        push(3, 1);
        send_word(W_SITTING, 7, 1'b0);

        // 3: THRESH=2 drops SITTING but the index still advances
        do_reset();
        mode = 2'd1;
        threshold = 8'd2;
        push(0, 0);
        send_word(W_KITTEN, 6, 1'b0);
        send_word(W_SITTING, 7, 1'b0);
        mode = 2'd0;
        push(0, 2);
        send_word(W_KITTEN, 6, 1'b0);

        // 4: BEST with tie, empty flush, then flush on a tlast beat
        do_reset();
        mode = 2'd2;
        send_word(W_SITTING, 7, 1'b0);
        send_word(W_KITTEN, 6, 1'b0);
        send_word(W_KITTEN, 6, 1'b0);
        push(0, 1);
        flush = 1'b1;
        @(negedge aclk);
        flush = 1'b0;
        push(255, 0);
        flush = 1'b1;
        @(negedge aclk);
        flush = 1'b0;
        push(3, 3);
        send_word(W_SITTING, 7, 1'b1);
        repeat (3) @(negedge aclk);

        // 5: backpressure, one-char words back to back, empty pattern
        do_reset();
        mode = 2'd0;
        m_tready = 1'b0;
        push(0, 0);
        send_word(W_KITTEN, 6, 1'b0);
        push(6, 1);
        s_tdata  = 16'h0000;
        s_tuser  = 1'b1;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_tready", 32'(s_tready), 32'd0);
            @(negedge aclk);
            #1;
        end
        m_tready = 1'b1;
        #1;
        chk("drain_tready", 32'(s_tready), 32'd1);
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        push(5, 2);
        push(5, 3);
        push(6, 4);
        t0 = $time;
        beat(16'h0001, 1'b1, 1'b1);
        beat(16'h0020, 1'b1, 1'b1);
        beat(16'h0000, 1'b1, 1'b1);
        chk("b2b_cycles", 32'(($time - t0) / 10), 32'd3);
        word_size = MW'(0);
        push(4, 5);
        send_word({16'hFFFF, 16'h0001, 16'h0020, 16'hFFFF}, 4, 1'b0);
        word_size = MW'(6);

        // 6: reset discards a held result and a partial word
        do_reset();
        m_tready = 1'b0;
        send_word(W_KITTEN, 6, 1'b0);
        do_reset();
        m_tready = 1'b1;
        beat(16'h0000, 1'b1, 1'b0);
        beat(16'h0002, 1'b0, 1'b0);
        do_reset();
        push(3, 0);
        send_word(W_SITTING, 7, 1'b0);

        repeat (4) @(negedge aclk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
